// File: rtl/mux_rr_arb_pkg.sv
// Shared widths and FSM state type for the round-robin 8:1 mux arbiter.
// Imported by the arbiter top and its pick sub-module.
package mux_rr_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request scanning ptr, ptr+1, ... modulo 8.
// Purely combinational, zero latency, no flow control.
module rr_pick8
  import mux_rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        found = 1'b1;
        idx   = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_arb_8to1.sv
// Round-robin owner of a 1-bit 8:1 mux; streams the holder's bit for up to MAX_BURST beats.
// One cycle request-to-valid, zero-bubble handover; out_rdy=0 freezes the holder indefinitely.
module mux_rr_arb_8to1
  import mux_rr_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] data,
  output logic [SEL_W-1:0]   sel,
  output logic               out_val,
  input  logic               out_rdy,
  output logic               out,
  output logic [NUM_REQ-1:0] gnt
);

  state_t             state;
  logic [SEL_W-1:0]   sel_r;
  logic [SEL_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic [SEL_W-1:0]   sel_next;
  logic [SEL_W-1:0]   idle_idx;
  logic               idle_found;
  logic [SEL_W-1:0]   rel_idx;
  logic               rel_found;
  logic               data_bit;
  logic               holder_req;
  logic               xfer;
  logic               last_beat;
  logic               release_now;

  assign sel_next = sel_r + SEL_W'(1);

  rr_pick8 u_pick_idle (
    .req   (req),
    .ptr   (ptr),
    .idx   (idle_idx),
    .found (idle_found)
  );

  // Release pick starts just past the holder, so a withdrawn holder is scanned last and skipped.
  rr_pick8 u_pick_release (
    .req   (req),
    .ptr   (sel_next),
    .idx   (rel_idx),
    .found (rel_found)
  );

  always_comb begin
    data_bit = 1'b0;
    case (sel_r)
      3'd0: data_bit = data[0];
      3'd1: data_bit = data[1];
      3'd2: data_bit = data[2];
      3'd3: data_bit = data[3];
      3'd4: data_bit = data[4];
      3'd5: data_bit = data[5];
      3'd6: data_bit = data[6];
      3'd7: data_bit = data[7];
      default: data_bit = 1'b0;
    endcase
  end

  assign holder_req  = req[sel_r];
  assign out_val     = (state == BUSY) && holder_req;
  assign out         = out_val && data_bit;
  assign xfer        = out_val && out_rdy;
  assign gnt         = xfer ? (NUM_REQ'(1) << sel_r) : '0;
  assign sel         = sel_r;
  assign last_beat   = (cnt == CNT_W'(MAX_BURST - 1));
  assign release_now = (state == BUSY) && (!holder_req || (xfer && last_beat));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel_r <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (idle_found) begin
        state <= BUSY;
        sel_r <= idle_idx;
        cnt   <= '0;
      end
    end else if (release_now) begin
      ptr <= sel_next;
      cnt <= '0;
      if (rel_found) begin
        sel_r <= rel_idx;
      end else begin
        state <= IDLE;
      end
    end else if (xfer) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/mux_rr_arb_8to1.md
# mux_rr_arb_8to1

Round-robin arbiter and sequencer that shares a 1-bit 8-to-1 mux channel among eight requesters. It picks one requester and drives the mux select. It then streams that requester's bit to a single downstream consumer over a val/rdy handshake, for at most MAX_BURST beats, before rotating priority. It sits between eight 1-bit producers and one 1-bit consumer and owns the mux select.

## Interface
- MAX_BURST, 4, maximum beats one requester may transfer per grant; legal range 1..15
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  8  per-requester request; bit i set means requester i has a valid bit on data[i]
- data  input  8  per-requester data bit
- sel  output  3  registered mux select (index of current holder)
- out_val  output  1  downstream valid
- out_rdy  input  1  downstream ready
- out  output  1  muxed data bit; forced to 0 when out_val=0
- gnt  output  8  one-hot; bit i set in exactly the cycle a beat from requester i transfers (out_val && out_rdy), else 0

## Operation
- State registers:
  - state: IDLE or BUSY
  - sel_r (3b): current holder
  - ptr (3b): highest-priority index
  - cnt (4b): beats transferred in the current grant
- Pick function: first index i with req[i]=1, scanning ptr, ptr+1, … mod 8. It returns found=0 if req=0.
- IDLE:
  - out_val=0, gnt=0.
  - If found: next state BUSY, sel_r<=pick(ptr), cnt<=0.
  - Otherwise stay IDLE; sel_r holds.
- BUSY, outputs:
  - out_val=req[sel_r].
  - out=data[sel_r] when out_val=1.
  - gnt=onehot(sel_r) when out_val && out_rdy.
- BUSY, beat:
  - A transfer is out_val && out_rdy; on a transfer cnt<=cnt+1.
- BUSY, release condition: either of
  - a transfer with cnt+1==MAX_BURST, or
  - req[sel_r]=0 (withdraw; no transfer that cycle).
- BUSY, on release:
  - ptr<=sel_r+1 (7 wraps to 0).
  - Re-arbitrate in the same cycle using pick(sel_r+1) over the current req. A withdrawn holder is not eligible because its req=0.
  - If found: stay BUSY, sel_r<=pick, cnt<=0. There is no bubble.
  - Else: go to IDLE.
  - A sole active requester is re-picked after its own burst; cnt restarts at 0.
- Backpressure: out_rdy=0 with out_val=1 holds sel_r, cnt, ptr and state. The holder keeps the channel indefinitely.
- Requests from non-holders never affect outputs in the current cycle.
- out_rdy is ignored when out_val=0.
- Reset (any time, including mid-burst): state=IDLE, sel_r=0, ptr=0, cnt=0. Outputs are therefore sel=0, out_val=0, out=0, gnt=0 immediately, without waiting for a clock edge.

## Timing
- Request-to-valid latency: a req first seen in IDLE at edge t produces sel and out_val=1 after edge t+1, i.e. one cycle.
- Back-to-back grants: handover on release has zero idle cycles. The new sel appears the cycle after the final beat or the withdraw.
- out, out_val and gnt are combinational from registered state plus current req, data and out_rdy. sel is purely registered.
- Throughput: one beat per cycle while out_rdy=1 and the holder keeps req high.
- Fairness: any requester holding req high is served within 7 grants of at most MAX_BURST beats each, subject to backpressure.

## Structure
- Shared package mux_rr_arb_pkg holds:
  - NUM_REQ=8
  - SEL_W=3
  - CNT_W=4
  - state enum {IDLE, BUSY}
- Sub-module rr_pick8: combinational; inputs req[7:0] and ptr[2:0]; outputs idx[2:0] and found. It is instantiated twice, once for the IDLE pick from ptr and once for the release pick from sel_r+1.
- The 8:1 data mux is a plain case on sel_r inside the top; no separate instance.

## Test plan
- Single requester, MAX_BURST=4: req=0x04, out_rdy=1 → out_val rises one cycle later with sel=2. gnt=0x04 every cycle with no gaps, because the sole requester is re-granted after each 4 beats. out tracks data[2].
- Strict rotation, MAX_BURST=1: req=0xFF, out_rdy=1 → sel sequence 0,1,2,…,7,0,1. gnt walks one-hot 0x01, 0x02, …, 0x80 with no bubbles.
- Backpressure: holder 3, out_rdy=0 for 5 cycles mid-burst → sel stays 3, out_val=1, gnt=0, cnt frozen. The burst resumes and completes its remaining beats after out_rdy returns to 1.
- Withdraw: holder 1 with cnt=1, req goes from 0x22 to 0x20 → out_val=0 that cycle. Next cycle sel=5, cnt=0, ptr=2.
- Wrap and skip: ptr=6 after release of holder 5, req=0x09 → next holder 0, then holder 3.
- Reset mid-burst: assert reset asynchronously during holder 4's second beat → sel=0, out_val=0, gnt=0, out=0 before the next edge. After deassert with req=0x10, sel=4 one cycle later with a full MAX_BURST budget.
